// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and helpers for the instruction fetch unit and its FIFOs.
package instruction_fetch_unit_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  // Pointer width for a power-of-two FIFO; a single-entry FIFO still needs one bit.
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Parameterised synchronous FIFO with registered storage, occupancy count and
// synchronous clear; used for both the pending-address FIFO and the prefetch queue.
module ifetch_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        data_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        head_o,
  output logic [ptr_w(DEPTH):0]   count_o
);

  localparam int PW   = ptr_w(DEPTH);
  localparam int CNTW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             do_pop_s;

  assign do_pop_s = pop_i && (count_q != '0);
  assign head_o   = mem_q[rd_ptr_q];
  assign count_o  = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_i, do_pop_s})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: credit-limited word reads, in-order response pairing,
// prefetch queue and flush draining. `IFETCH_ALIGN_CHECK_EN adds fetch_fault.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              pc_advance,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic              fetch_fault
`endif
);

  localparam int QPW = ptr_w(DEPTH);
  localparam int OPW = ptr_w(MAX_OUTSTANDING);
  localparam int CW  = QPW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);

  fetch_state_e               state_q, state_d;
  logic [CW-1:0]              drop_q, drop_d;
  logic [QPW:0]               q_count_s;
  logic [OPW:0]               pend_count_s;
  logic [CW-1:0]              q_cnt_w_s, out_w_s, out_d_s;
  logic [ADDR_W-1:0]          pend_head_s;
  logic [INST_W+ADDR_W-1:0]   q_head_s;
  logic                       align_ok_s, accept_s, drop_resp_s, q_push_s, q_pop_s;

  assign q_cnt_w_s = CW'(q_count_s);
  assign out_w_s   = CW'(pend_count_s);

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q;

  assign align_ok_s  = (pc[1:0] == 2'b00) && !fault_q;
  assign fetch_fault = fault_q;

  // Sticky misalignment fault; only a redirect clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_q <= 1'b0;
    end else if (flush) begin
      fault_q <= 1'b0;
    end else if ((state_q == ST_RUN) && (pc[1:0] != 2'b00)) begin
      fault_q <= 1'b1;
    end else begin
      fault_q <= fault_q;
    end
  end
`else
  assign align_ok_s = 1'b1;
`endif

  // Credit: queued plus in-flight entries may never exceed the queue depth.
  assign mem_req     = reset && (state_q == ST_RUN) && !flush && align_ok_s &&
                       (out_w_s < MAX_C) && ((q_cnt_w_s + out_w_s) < DEPTH_C);
  assign accept_s    = mem_req && mem_ready;
  assign pc_advance  = accept_s;
  assign mem_addr    = {pc[ADDR_W-1:2], 2'b00};

  assign drop_resp_s = mem_rvalid && (drop_q != '0);
  assign q_push_s    = mem_rvalid && !drop_resp_s;
  assign inst_valid  = (q_count_s != '0);
  assign q_pop_s     = inst_valid && inst_ready;
  assign inst        = q_head_s[INST_W+ADDR_W-1:ADDR_W];
  assign inst_pc     = q_head_s[ADDR_W-1:0];
  assign out_d_s     = out_w_s + CW'(accept_s) - CW'(mem_rvalid);

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    if (drop_resp_s) begin
      drop_d = drop_q - CW'(1);
    end else begin
      drop_d = drop_q;
    end
    // Flush counts every request still in flight once this cycle settles.
    if (flush) begin
      drop_d  = out_d_s;
      state_d = (out_d_s != '0) ? ST_DRAIN : ST_RUN;
    end else if ((state_q == ST_DRAIN) && (drop_d == '0)) begin
      state_d = ST_RUN;
    end else begin
      state_d = state_q;
    end
  end

  // Fetch state and stale-response drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  ifetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pending (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clr_i   (1'b0),
    .push_i  (accept_s),
    .data_i  (pc),
    .pop_i   (mem_rvalid),
    .head_o  (pend_head_s),
    .count_o (pend_count_s)
  );

  ifetch_fifo #(
    .WIDTH (INST_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clr_i   (flush),
    .push_i  (q_push_s),
    .data_i  ({mem_rdata, pend_head_s}),
    .pop_i   (q_pop_s),
    .head_o  (q_head_s),
    .count_o (q_count_s)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed, table-driven bench for instruction_fetch_unit (default DEPTH=4, MAX_OUTSTANDING=2).
module tb_instruction_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic        mr;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        e_req;
    logic        e_adv;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_inst;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        flush;
  logic        pc_advance;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .flush      (flush),
    .pc_advance (pc_advance),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault(fetch_fault)
`endif
  );

  function automatic vec_t mk(input logic [31:0] p, input logic f, input logic m, input logic r,
                              input logic [31:0] d, input logic i, input logic eq, input logic ea,
                              input logic ev, input logic [31:0] ep, input logic [31:0] ei);
    vec_t t;
    t.pc = p; t.fl = f; t.mr = m; t.rv = r; t.rd = d; t.ir = i;
    t.e_req = eq; t.e_adv = ea; t.e_iv = ev; t.e_ipc = ep; t.e_inst = ei;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then check outputs before the rising edge.
  task automatic run(input vec_t t, input string tag);
    logic [31:0] exp_addr;
    @(negedge clk);
    pc = t.pc; flush = t.fl; mem_ready = t.mr; mem_rvalid = t.rv;
    mem_rdata = t.rd; inst_ready = t.ir;
    #1;
    exp_addr = {t.pc[31:2], 2'b00};
    chk({tag, ".mem_req"}, {31'd0, mem_req}, {31'd0, t.e_req});
    chk({tag, ".pc_advance"}, {31'd0, pc_advance}, {31'd0, t.e_adv});
    if (t.e_req) chk({tag, ".mem_addr"}, mem_addr, exp_addr);
    chk({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, t.e_iv});
    if (t.e_iv) begin
      chk({tag, ".inst_pc"}, inst_pc, t.e_ipc);
      chk({tag, ".inst"}, inst, t.e_inst);
    end
  endtask

  initial begin
    reset = 1'b0; pc = 32'd0; flush = 1'b0; mem_ready = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0; inst_ready = 1'b0;

    // Streaming, latency 1, decode always ready
    tbl.push_back(mk(32'h0,  1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0));
    tbl.push_back(mk(32'h4,  1'b0, 1'b1, 1'b1, 32'hA000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0));
    tbl.push_back(mk(32'h8,  1'b0, 1'b1, 1'b1, 32'hA000_0004, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,  32'hA000_0000));
    tbl.push_back(mk(32'hC,  1'b0, 1'b1, 1'b1, 32'hA000_0008, 1'b1, 1'b1, 1'b1, 1'b1, 32'h4,  32'hA000_0004));
    tbl.push_back(mk(32'h10, 1'b0, 1'b1, 1'b1, 32'hA000_000C, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8,  32'hA000_0008));
    tbl.push_back(mk(32'h14, 1'b0, 1'b0, 1'b1, 32'hA000_0010, 1'b1, 1'b1, 1'b0, 1'b1, 32'hC,  32'hA000_000C));
    tbl.push_back(mk(32'h14, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'hA000_0010));
    tbl.push_back(mk(32'h14, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0));
    // Backpressure: decode stalled, queue fills to four
    tbl.push_back(mk(32'h0,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0));
    tbl.push_back(mk(32'h4,  1'b0, 1'b1, 1'b1, 32'hB000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0));
    tbl.push_back(mk(32'h8,  1'b0, 1'b1, 1'b1, 32'hB000_0004, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0,  32'hB000_0000));
    tbl.push_back(mk(32'hC,  1'b0, 1'b1, 1'b1, 32'hB000_0008, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0,  32'hB000_0000));
    tbl.push_back(mk(32'h10, 1'b0, 1'b1, 1'b1, 32'hB000_000C, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  32'hB000_0000));
    tbl.push_back(mk(32'h10, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  32'hB000_0000));
    tbl.push_back(mk(32'h10, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  32'hB000_0000));
    tbl.push_back(mk(32'h10, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'h4,  32'hB000_0004));
    tbl.push_back(mk(32'h14, 1'b0, 1'b1, 1'b1, 32'hB000_0010, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4,  32'hB000_0004));
    tbl.push_back(mk(32'h14, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h4,  32'hB000_0004));
    tbl.push_back(mk(32'h14, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h4,  32'hB000_0004));
    tbl.push_back(mk(32'h14, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 32'h8,  32'hB000_0008));
    tbl.push_back(mk(32'h14, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 32'hC,  32'hB000_000C));
    tbl.push_back(mk(32'h14, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'hB000_0010));
    tbl.push_back(mk(32'h14, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0));
    // Memory stall: three cycles not ready at 0x100
    tbl.push_back(mk(32'h100, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0));
    tbl.push_back(mk(32'h100, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0));
    tbl.push_back(mk(32'h100, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0));
    tbl.push_back(mk(32'h100, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0));
    tbl.push_back(mk(32'h104, 1'b0, 1'b0, 1'b1, 32'hD000_0100, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0));
    tbl.push_back(mk(32'h104, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'hD000_0100));
    tbl.push_back(mk(32'h104, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0));

    // Reset state
    @(negedge clk);
    #1;
    chk("rst.mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst.pc_advance", {31'd0, pc_advance}, 32'd0);
    chk("rst.inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst.inst", inst, 32'd0);
    chk("rst.inst_pc", inst_pc, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[k]) run(tbl[k], $sformatf("tbl%0d", k));

    // Flush with two requests in flight, latency 5; redirect to 0x400
    run(mk(32'h18,  1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0), "fl0");
    run(mk(32'h1C,  1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0), "fl1");
    run(mk(32'h20,  1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0), "fl2");
    run(mk(32'h400, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0), "fl3");
    run(mk(32'h400, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0), "fl4");
    run(mk(32'h400, 1'b0, 1'b1, 1'b1, 32'hDEAD_0018, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0), "fl5");
    run(mk(32'h400, 1'b0, 1'b1, 1'b1, 32'hDEAD_001C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0), "fl6");
    run(mk(32'h400, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0), "fl7");
    for (int c = 8; c < 12; c++)
      run(mk(32'h404, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0), $sformatf("fl%0d", c));
    run(mk(32'h404, 1'b0, 1'b0, 1'b1, 32'hE000_0400, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0), "fl12");
    run(mk(32'h404, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 32'h400, 32'hE000_0400), "fl13");
    run(mk(32'h404, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0), "fl14");

    // Push and pop together with four entries committed, then flushes in DRAIN
    run(mk(32'h40,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0), "pp0");
    run(mk(32'h44,  1'b0, 1'b1, 1'b1, 32'h5000_0040, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0), "pp1");
    run(mk(32'h48,  1'b0, 1'b1, 1'b1, 32'h5000_0044, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h5000_0040), "pp2");
    run(mk(32'h4C,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h5000_0040), "pp3");
    run(mk(32'h50,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h5000_0040), "pp4");
    run(mk(32'h50,  1'b0, 1'b1, 1'b1, 32'h5000_0048, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h5000_0040), "pp5");
    run(mk(32'h50,  1'b0, 1'b1, 1'b1, 32'h5000_004C, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h5000_0040), "pp6");
    run(mk(32'h50,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'h44, 32'h5000_0044), "pp7");
    run(mk(32'h50,  1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 32'h5000_0044), "pp8");
    run(mk(32'h600, 1'b1, 1'b1, 1'b1, 32'hDEAD_0050, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0), "pp9");
    run(mk(32'h600, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0), "pp10");
    run(mk(32'h604, 1'b0, 1'b0, 1'b1, 32'h5000_0600, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0), "pp11");
    run(mk(32'h604, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 32'h600, 32'h5000_0600), "pp12");
    run(mk(32'h604, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0), "pp13");

`ifdef IFETCH_ALIGN_CHECK_EN
    // Misaligned pc raises a sticky fault that only a redirect clears
    run(mk(32'h102, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0), "al0");
    chk("al0.fetch_fault", {31'd0, fetch_fault}, 32'd0);
    run(mk(32'h104, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0), "al1");
    chk("al1.fetch_fault", {31'd0, fetch_fault}, 32'd1);
    run(mk(32'h200, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0), "al2");
    chk("al2.fetch_fault", {31'd0, fetch_fault}, 32'd1);
    run(mk(32'h200, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0), "al3");
    chk("al3.fetch_fault", {31'd0, fetch_fault}, 32'd0);
    run(mk(32'h204, 1'b0, 1'b0, 1'b1, 32'h7700_0200, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0), "al4");
    run(mk(32'h204, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'h7700_0200), "al5");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
